// File: rtl/edge_pkg.sv
// rtl/edge_pkg.sv - shared state and request encodings for edge generation blocks
package edge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE_LOW   = 2'd0,
      ST_HIGH_DWELL = 2'd1,
      ST_IDLE_HIGH  = 2'd2,
      ST_LOW_DWELL  = 2'd3
   } edge_state_t;

   typedef enum logic [1:0] {
      REQ_NONE  = 2'd0,
      REQ_RISE  = 2'd1,
      REQ_FALL  = 2'd2,
      REQ_PULSE = 2'd3
   } edge_req_t;

   // Both requests together encode as a pulse.
   function automatic edge_req_t req_encode(input logic rise, input logic fall);
      return edge_req_t'({fall, rise});
   endfunction

endpackage

// File: rtl/edge_dwell_counter.sv
// rtl/edge_dwell_counter.sv - loadable down-counter that stops at zero and flags it
module edge_dwell_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/edge_generator.sv
// rtl/edge_generator.sv - dwell-limited level generator with rise/fall/err strobes
// Optional one-entry request slot during dwell: EDGE_GENERATOR_QUEUE_EN
module edge_generator
   import edge_pkg::*;
#(
   parameter int MIN_HIGH = 3,
   parameter int MIN_LOW  = 2,
   parameter int CNT_W    = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic req_rise,
   input  logic req_fall,
   output logic ready,
   output logic sig,
   output logic r,
   output logic f,
   output logic err
);

   localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(MIN_HIGH - 1);
   localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(MIN_LOW - 1);

   edge_state_t state;
   edge_req_t   req_code;
   edge_req_t   exec;
   logic        pend;
   logic        cnt_zero;
   logic        dwell;
   logic        accept;
   logic        do_rise;
   logic        do_fall;
   logic        set_err;
   logic        set_pend;
   logic        clr_pend;

   assign dwell    = (state == ST_HIGH_DWELL) || (state == ST_LOW_DWELL);
   assign req_code = req_encode(req_rise, req_fall);

`ifdef EDGE_GENERATOR_QUEUE_EN
   edge_req_t slot;
   logic      store;
   logic      fire_slot;

   // A full slot holds ready low, including the cycle it executes in.
   assign ready     = !pend && (!dwell || (slot == REQ_NONE));
   assign accept    = ready && (req_rise || req_fall);
   assign store     = accept && dwell && !cnt_zero;
   assign fire_slot = dwell && cnt_zero && (slot != REQ_NONE);
   assign exec      = fire_slot ? slot : ((accept && !store) ? req_code : REQ_NONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot <= REQ_NONE;
      end else if (store) begin
         slot <= req_code;
      end else if (fire_slot) begin
         slot <= REQ_NONE;
      end
   end
`else
   assign ready  = !pend && (!dwell || cnt_zero);
   assign accept = ready && (req_rise || req_fall);
   assign exec   = accept ? req_code : REQ_NONE;
`endif

   always_comb begin
      do_rise  = 1'b0;
      do_fall  = 1'b0;
      set_err  = 1'b0;
      set_pend = 1'b0;
      clr_pend = 1'b0;
      unique case (exec)
         REQ_RISE: begin
            if (sig) set_err = 1'b1;
            else     do_rise = 1'b1;
         end
         REQ_FALL: begin
            if (!sig) set_err = 1'b1;
            else      do_fall = 1'b1;
         end
         REQ_PULSE: begin
            set_pend = 1'b1;
            if (sig) do_fall = 1'b1;
            else     do_rise = 1'b1;
         end
         default: begin
            // Second half of a pulse fires once the first dwell has elapsed.
            if (pend && dwell && cnt_zero) begin
               clr_pend = 1'b1;
               if (sig) do_fall = 1'b1;
               else     do_rise = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE_LOW;
         sig   <= 1'b0;
         r     <= 1'b0;
         f     <= 1'b0;
         err   <= 1'b0;
         pend  <= 1'b0;
      end else begin
         r   <= do_rise;
         f   <= do_fall;
         err <= set_err;
         if (set_pend)      pend <= 1'b1;
         else if (clr_pend) pend <= 1'b0;
         if (do_rise) begin
            sig   <= 1'b1;
            state <= ST_HIGH_DWELL;
         end else if (do_fall) begin
            sig   <= 1'b0;
            state <= ST_LOW_DWELL;
         end else if (dwell && cnt_zero) begin
            state <= sig ? ST_IDLE_HIGH : ST_IDLE_LOW;
         end
      end
   end

   edge_dwell_counter #(
      .CNT_W(CNT_W)
   ) u_dwell (
      .clk      (clk),
      .rst      (rst),
      .load     (do_rise | do_fall),
      .load_val (do_rise ? HIGH_LOAD : LOW_LOAD),
      .zero     (cnt_zero)
   );

endmodule
